// File: rtl/aig_seq_eval.sv
// Sequential And-Inverter-Graph evaluator. It holds a programmable node table,
// evaluates one AND node per cycle, and returns the selected output literals.
module aig_seq_eval #(
    parameter  int NUM_PI    = 3,
    parameter  int NUM_PO    = 4,
    parameter  int MAX_NODES = 32,
    localparam int VAL_N     = 1 + NUM_PI + MAX_NODES,
    localparam int IDX_W     = $clog2(VAL_N),
    localparam int LIT_W     = IDX_W + 1,
    localparam int ADDR_W    = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
    localparam int PO_W      = (NUM_PO > 1) ? $clog2(NUM_PO) : 1,
    localparam int NUM_W     = $clog2(MAX_NODES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_node_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [LIT_W-1:0]  cfg_lit0,
    input  logic [LIT_W-1:0]  cfg_lit1,
    input  logic              cfg_po_we,
    input  logic [PO_W-1:0]   cfg_po_idx,
    input  logic [LIT_W-1:0]  cfg_po_lit,
    input  logic              cfg_num_we,
    input  logic [NUM_W-1:0]  cfg_num_nodes,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_PI-1:0] in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NUM_PO-1:0] out_vec,
    output logic              busy,
    output logic              err
);

    localparam int LIM_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [LIT_W-1:0]   r_lit0  [MAX_NODES];
    logic [LIT_W-1:0]   r_lit1  [MAX_NODES];
    logic [LIT_W-1:0]   r_poLit [NUM_PO];
    logic [NUM_W-1:0]   r_numNodes;
    logic [ADDR_W-1:0]  r_k;
    logic [VAL_N-1:0]   r_val;
    logic [NUM_PO-1:0]  r_outVec;
    logic               r_err;

    logic               w_idle;
    logic               w_eval;
    logic               w_accept;
    logic               w_cfgAny;
    logic               w_numOver;
    logic [NUM_W-1:0]   w_numSat;
    logic [NUM_W-1:0]   w_numEff;
    logic               w_lastNode;
    logic [LIT_W-1:0]   w_lit0;
    logic [LIT_W-1:0]   w_lit1;
    logic [LIM_W-1:0]   w_limit;
    logic               w_oor0;
    logic               w_oor1;
    logic               w_nodeVal;
    logic [VAL_N-1:0]   w_valNext;
    logic [LIT_W-1:0]   w_poLitEff [NUM_PO];
    logic [NUM_PO-1:0]  w_poVec;
    logic               w_loadOut;
    logic               w_errSet;

    function automatic logic litVal(input logic [VAL_N-1:0] vals, input logic [LIT_W-1:0] lit);
        logic [IDX_W-1:0] idx;
        idx = lit[LIT_W-1:1];
        if (int'(idx) < VAL_N) begin
            return vals[idx] ^ lit[0];
        end
        return lit[0];
    endfunction

    assign w_idle     = (r_state == IDLE);
    assign w_eval     = (r_state == EVAL);
    assign w_accept   = w_idle && in_valid;
    assign w_cfgAny   = cfg_node_we || cfg_po_we || cfg_num_we;
    assign w_numOver  = (cfg_num_nodes > NUM_W'(MAX_NODES));
    assign w_numSat   = w_numOver ? NUM_W'(MAX_NODES) : cfg_num_nodes;
    assign w_numEff   = (w_idle && cfg_num_we) ? w_numSat : r_numNodes;
    assign w_lastNode = w_eval && ((NUM_W'(r_k) + NUM_W'(1)) == r_numNodes);
    assign w_loadOut  = (w_accept && (w_numEff == '0)) || w_lastNode;

    // A fanin pointing at a node not yet evaluated this pass contributes 0 to the AND.
    assign w_lit0    = r_lit0[r_k];
    assign w_lit1    = r_lit1[r_k];
    assign w_limit   = LIM_W'(NUM_PI + 1) + LIM_W'(r_k);
    assign w_oor0    = ({1'b0, w_lit0[LIT_W-1:1]} >= w_limit);
    assign w_oor1    = ({1'b0, w_lit1[LIT_W-1:1]} >= w_limit);
    assign w_nodeVal = (w_oor0 ? 1'b0 : litVal(r_val, w_lit0)) &
                       (w_oor1 ? 1'b0 : litVal(r_val, w_lit1));

    assign w_errSet = (!w_idle && w_cfgAny) ||
                      (w_idle && cfg_num_we && w_numOver) ||
                      (w_eval && (w_oor0 || w_oor1));

    // Value vector as it will look after this edge, so the result register
    // can capture outputs that depend on the node finishing this cycle.
    always_comb begin
        w_valNext = r_val;
        if (w_accept) begin
            w_valNext = VAL_N'({in_vec, 1'b0});
        end else if (w_eval) begin
            w_valNext[NUM_PI + 1 + int'(r_k)] = w_nodeVal;
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_PO; j++) begin
            w_poLitEff[j] = r_poLit[j];
            if (w_idle && cfg_po_we && (int'(cfg_po_idx) == j)) begin
                w_poLitEff[j] = cfg_po_lit;
            end
            w_poVec[j] = litVal(w_valNext, w_poLitEff[j]);
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_stateNext = (w_numEff == '0) ? DONE : EVAL;
                end
            end
            EVAL: begin
                if (w_lastNode) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < MAX_NODES; n++) begin
                r_lit0[n] <= '0;
                r_lit1[n] <= '0;
            end
            for (int j = 0; j < NUM_PO; j++) begin
                r_poLit[j] <= '0;
            end
            r_numNodes <= '0;
        end else if (w_idle) begin
            if (cfg_node_we) begin
                r_lit0[cfg_addr] <= cfg_lit0;
                r_lit1[cfg_addr] <= cfg_lit1;
            end
            if (cfg_po_we) begin
                r_poLit[cfg_po_idx] <= cfg_po_lit;
            end
            if (cfg_num_we) begin
                r_numNodes <= w_numSat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val    <= '0;
            r_k      <= '0;
            r_outVec <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_val <= w_valNext;
                r_k   <= '0;
            end else if (w_eval) begin
                r_val <= w_valNext;
                if (!w_lastNode) begin
                    r_k <= r_k + ADDR_W'(1);
                end
            end
            if (w_loadOut) begin
                r_outVec <= w_poVec;
            end
            if (w_errSet) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready  = w_idle;
    assign out_valid = (r_state == DONE);
    assign busy      = !w_idle;
    assign out_vec   = r_outVec;
    assign err       = r_err;

endmodule

// File: tb/tb_aig_seq_eval.sv
// Directed bench for aig_seq_eval: a vector table over three small programs
// plus hand-written sequences for backpressure, config hazards and reset.
module tb_aig_seq_eval;

    logic       clk;
    logic       rst_n;
    logic       cfg_node_we;
    logic [4:0] cfg_addr;
    logic [6:0] cfg_lit0;
    logic [6:0] cfg_lit1;
    logic       cfg_po_we;
    logic [1:0] cfg_po_idx;
    logic [6:0] cfg_po_lit;
    logic       cfg_num_we;
    logic [5:0] cfg_num_nodes;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_vec;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         prog;
        logic [2:0] inVec;
        logic [3:0] expOut;
        int         expLat;
    } vec_t;

    aig_seq_eval dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_node_we  (cfg_node_we),
        .cfg_addr     (cfg_addr),
        .cfg_lit0     (cfg_lit0),
        .cfg_lit1     (cfg_lit1),
        .cfg_po_we    (cfg_po_we),
        .cfg_po_idx   (cfg_po_idx),
        .cfg_po_lit   (cfg_po_lit),
        .cfg_num_we   (cfg_num_we),
        .cfg_num_nodes(cfg_num_nodes),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vec       (in_vec),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_vec      (out_vec),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        cfg_node_we = 0; cfg_addr = 0; cfg_lit0 = 0; cfg_lit1 = 0;
        cfg_po_we = 0; cfg_po_idx = 0; cfg_po_lit = 0;
        cfg_num_we = 0; cfg_num_nodes = 0;
        in_valid = 0; in_vec = 0; out_ready = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 0;
        clearInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic writeNode(input int k, input int l0, input int l1);
        cfg_node_we = 1; cfg_addr = 5'(k); cfg_lit0 = 7'(l0); cfg_lit1 = 7'(l1);
        @(posedge clk);
        #1;
        cfg_node_we = 0;
    endtask

    task automatic writePo(input int j, input int lit);
        cfg_po_we = 1; cfg_po_idx = 2'(j); cfg_po_lit = 7'(lit);
        @(posedge clk);
        #1;
        cfg_po_we = 0;
    endtask

    task automatic writeNum(input int n);
        cfg_num_we = 1; cfg_num_nodes = 6'(n);
        @(posedge clk);
        #1;
        cfg_num_we = 0;
    endtask

    task automatic loadProg(input int p);
        case (p)
            1: begin
                writeNode(0, 2, 6);
                writePo(0, 8); writePo(1, 9); writePo(2, 0); writePo(3, 1);
                writeNum(1);
            end
            2: begin
                writeNode(0, 3, 4);
                writeNode(1, 8, 7);
                writePo(0, 8); writePo(1, 9); writePo(2, 10); writePo(3, 11);
                writeNum(2);
            end
            default: begin
                writePo(0, 0); writePo(1, 0); writePo(2, 1); writePo(3, 1);
                writeNum(0);
            end
        endcase
    endtask

    // Launch one vector and count edges from acceptance until out_valid.
    task automatic applyStimulus(input logic [2:0] v, output logic [3:0] outV, output int lat);
        in_vec = v;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        outV = out_vec;
    endtask

    task automatic finishOut();
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
    endtask

    task automatic runCase(input logic [2:0] v, input logic [3:0] expOut, input int expLat, input string name);
        logic [3:0] got;
        int         lat;
        applyStimulus(v, got, lat);
        checkOutput({name, "_out"}, 32'(got), 32'(expOut));
        checkOutput({name, "_lat"}, 32'(lat), 32'(expLat));
        finishOut();
    endtask

    vec_t       vecs [13];
    int         curProg;
    logic [3:0] got;
    int         lat;
    logic       sawValid;

    initial begin
        vecs[0]  = '{1, 3'b000, 4'b1010, 2};
        vecs[1]  = '{1, 3'b001, 4'b1010, 2};
        vecs[2]  = '{1, 3'b010, 4'b1010, 2};
        vecs[3]  = '{1, 3'b011, 4'b1010, 2};
        vecs[4]  = '{1, 3'b100, 4'b1010, 2};
        vecs[5]  = '{1, 3'b101, 4'b1001, 2};
        vecs[6]  = '{1, 3'b110, 4'b1010, 2};
        vecs[7]  = '{1, 3'b111, 4'b1001, 2};
        vecs[8]  = '{2, 3'b010, 4'b0101, 3};
        vecs[9]  = '{2, 3'b110, 4'b1001, 3};
        vecs[10] = '{2, 3'b011, 4'b1010, 3};
        vecs[11] = '{3, 3'b000, 4'b1100, 1};
        vecs[12] = '{3, 3'b111, 4'b1100, 1};

        rst_n = 0;
        clearInputs();
        doReset();

        checkOutput("rst_state", {27'd0, in_ready, out_valid, busy, err, 1'b0}, {27'd0, 5'b10000});
        checkOutput("rst_outvec", 32'(out_vec), 32'd0);
        runCase(3'b111, 4'b0000, 1, "rst_emptyTable");

        curProg = 0;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].prog != curProg) begin
                loadProg(vecs[i].prog);
                curProg = vecs[i].prog;
            end
            runCase(vecs[i].inVec, vecs[i].expOut, vecs[i].expLat, $sformatf("vec%0d", i));
        end
        checkOutput("table_noErr", 32'(err), 32'd0);

        // Backpressure: result held while out_ready is low, config writes refused.
        loadProg(1);
        applyStimulus(3'b101, got, lat);
        checkOutput("hold_lat", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold_c%0d", c), {27'd0, out_valid, in_ready, out_vec}, {27'd0, 6'b101001});
        end
        writeNode(0, 0, 0);
        checkOutput("busyCfg_err", 32'(err), 32'd1);
        checkOutput("busyCfg_stillDone", 32'(out_valid), 32'd1);
        finishOut();
        checkOutput("release_inReady", 32'(in_ready), 32'd1);
        runCase(3'b101, 4'b1001, 2, "ignoredWrite");

        // Config and input in the same idle cycle: new count and output literal apply.
        doReset();
        writeNum(1);
        cfg_num_we = 1; cfg_num_nodes = 0;
        cfg_po_we = 1; cfg_po_idx = 0; cfg_po_lit = 7'd4;
        in_valid = 1; in_vec = 3'b010;
        @(posedge clk);
        #1;
        clearInputs();
        checkOutput("sameCycle_valid", 32'(out_valid), 32'd1);
        checkOutput("sameCycle_out", 32'(out_vec), 32'b0001);
        finishOut();

        // Oversized node count saturates to the table depth.
        doReset();
        writeNum(40);
        checkOutput("sat_err", 32'(err), 32'd1);
        runCase(3'b000, 4'b0000, 33, "sat");

        // Forward reference to a later node reads as 0 and flags err.
        doReset();
        loadProg(1);
        writeNode(0, 10, 2);
        checkOutput("fwdRef_preErr", 32'(err), 32'd0);
        runCase(3'b101, 4'b1010, 2, "fwdRef");
        checkOutput("fwdRef_err", 32'(err), 32'd1);

        // Reset in the middle of a 10-node evaluation.
        doReset();
        for (int k = 0; k < 10; k++) writeNode(k, 3, 3);
        writePo(0, 1);
        writeNum(10);
        in_vec = 3'b000;
        in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        checkOutput("midRst_outs", {28'd0, out_valid, busy, in_ready, 1'b0}, {28'd0, 4'b0010});
        checkOutput("midRst_outvec", 32'(out_vec), 32'd0);
        @(negedge clk);
        rst_n = 1;
        sawValid = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1;
        end
        checkOutput("midRst_noResult", 32'(sawValid), 32'd0);
        runCase(3'b000, 4'b0000, 1, "midRst_cleared");
        writeNum(1);
        writePo(0, 8);
        runCase(3'b000, 4'b0000, 2, "midRst_nodesCleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
